// File: rtl/pwm_duty_ctrl.sv
// PWM generator with double-buffered duty/period; new settings take effect at a period wrap.
// Latency: pwm_out/period_end are registered from next-state values, so they track cnt with zero added delay.
// Backpressure: wr_req is held until wr_ack; a second write stalls while one is still pending.
module pwm_duty_ctrl #(
    parameter int W          = 8,
    parameter int PERIOD_RST = 255,
    parameter int DUTY_RST   = 0
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         en,
    input  logic         wr_req,
    input  logic [W-1:0] wr_duty,
    input  logic [W-1:0] wr_period,
    output logic         wr_ack,
    output logic         pwm_out,
    output logic         period_end,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] duty_sh, duty_n;
    logic [W-1:0] period_sh, period_n;
    logic [W-1:0] pend_duty, pend_duty_n;
    logic [W-1:0] pend_period, pend_period_n;
    logic         pend_v, pend_v_n;
    logic         ack_n;
    logic         accept;
    logic         wrap;

    // A request is not re-sampled in its own acknowledge cycle.
    assign accept = wr_req && !wr_ack;
    assign wrap   = (state != IDLE) && (cnt == period_sh);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        duty_n        = duty_sh;
        period_n      = period_sh;
        pend_duty_n   = pend_duty;
        pend_period_n = pend_period;
        pend_v_n      = pend_v;
        ack_n         = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    duty_n   = wr_duty;
                    period_n = wr_period;
                    ack_n    = 1'b1;
                end
                if (en) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            default: begin
                cnt_n = wrap ? '0 : cnt + W'(1);
                if (en)
                    state_n = RUN;
                else
                    state_n = (state == STOP && wrap) ? IDLE : STOP;
                if (wrap && pend_v) begin
                    duty_n   = pend_duty;
                    period_n = pend_period;
                    pend_v_n = 1'b0;
                end
                // The pending slot frees up at the same edge it drains, so a stalled write lands here.
                if (accept && (!pend_v || wrap)) begin
                    ack_n = 1'b1;
                    if (state_n == IDLE) begin
                        duty_n   = wr_duty;
                        period_n = wr_period;
                    end else begin
                        pend_duty_n   = wr_duty;
                        pend_period_n = wr_period;
                        pend_v_n      = 1'b1;
                    end
                end
                if (state_n == IDLE)
                    cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            duty_sh     <= W'(DUTY_RST);
            period_sh   <= W'(PERIOD_RST);
            pend_duty   <= '0;
            pend_period <= '0;
            pend_v      <= 1'b0;
            wr_ack      <= 1'b0;
            pwm_out     <= 1'b0;
            period_end  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            duty_sh     <= duty_n;
            period_sh   <= period_n;
            pend_duty   <= pend_duty_n;
            pend_period <= pend_period_n;
            pend_v      <= pend_v_n;
            wr_ack      <= ack_n;
            pwm_out     <= (state_n != IDLE) && (cnt_n < duty_n);
            period_end  <= (state_n != IDLE) && (cnt_n == period_n);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a period-level behavioural model.
module tb_pwm_duty_ctrl;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_duty = '0;
    logic [7:0] wr_period = '0;
    logic       wr_ack, pwm_out, period_end, busy;

    int errors = 0;
    int checks = 0;

    pwm_duty_ctrl #(.W(8), .PERIOD_RST(255), .DUTY_RST(0)) dut (
        .ck(ck), .rst(rst), .en(en), .wr_req(wr_req), .wr_duty(wr_duty),
        .wr_period(wr_period), .wr_ack(wr_ack), .pwm_out(pwm_out),
        .period_end(period_end), .busy(busy)
    );

    always #5 ck = ~ck;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: running/stopping flags, position in period, active settings, a one-deep pending queue.
    bit m_on = 0, m_stopping = 0, m_ack = 0;
    int m_cnt = 0, m_duty = 0, m_per = 255;
    int pq_duty[$], pq_per[$];

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            m_on = 0; m_stopping = 0; m_ack = 0; m_cnt = 0; m_duty = 0; m_per = 255;
            pq_duty.delete(); pq_per.delete();
        end else begin
            bit take, last, to_idle;
            take = wr_req && !m_ack;
            m_ack = 0;
            if (!m_on) begin
                if (take) begin m_duty = wr_duty; m_per = wr_period; m_ack = 1; end
                if (en) begin m_on = 1; m_stopping = 0; m_cnt = 0; end
            end else begin
                last    = (m_cnt == m_per);
                to_idle = m_stopping && !en && last;
                if (last && pq_duty.size() > 0) begin
                    m_duty = pq_duty.pop_front();
                    m_per  = pq_per.pop_front();
                end
                if (take && pq_duty.size() == 0) begin
                    m_ack = 1;
                    if (to_idle) begin m_duty = wr_duty; m_per = wr_period; end
                    else begin pq_duty.push_back(wr_duty); pq_per.push_back(wr_period); end
                end
                m_cnt = last ? 0 : m_cnt + 1;
                m_stopping = !en;
                if (to_idle) begin m_on = 0; m_cnt = 0; end
            end
        end
    end

    always @(negedge ck) begin
        chk("pwm_out", pwm_out, int'(m_on && m_cnt < m_duty));
        chk("period_end", period_end, int'(m_on && m_cnt == m_per));
        chk("busy", busy, int'(m_on));
        chk("wr_ack", wr_ack, int'(m_ack));
    end

    // Per-period statistics for the directed literal checks.
    int cyc = 0, hi = 0, len = 0, pe_total = 0, ack_total = 0, last_pe = -1, last_ack = -1;
    int per_hi[$], per_len[$];
    always @(negedge ck) begin
        cyc++;
        if (wr_ack) begin ack_total++; last_ack = cyc; end
        if (!busy || rst) begin hi = 0; len = 0; end
        else begin
            len++;
            hi += int'(pwm_out);
            if (period_end) begin
                per_hi.push_back(hi); per_len.push_back(len);
                hi = 0; len = 0; pe_total++; last_pe = cyc;
            end
        end
    end

    task automatic do_write(input int d, input int p, output int waited);
        bit got = 0;
        wr_duty = 8'(d); wr_period = 8'(p); wr_req = 1'b1; waited = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge ck);
            waited++;
            got = wr_ack;
        end
        if (!got) chk("write_timeout", 0, 1);
        wr_req = 1'b0;
    endtask

    task automatic wait_pe(input int n);
        int seen = 0;
        for (int i = 0; i < 2000 && seen < n; i++) begin
            @(negedge ck);
            if (period_end) seen++;
        end
        if (seen < n) chk("period_end_timeout", seen, n);
        #1;
    endtask

    task automatic wait_cnt(input int v);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge ck);
            hit = busy && (m_cnt == v);
        end
        if (!hit) chk("wait_cnt_timeout", 0, 1);
    endtask

    task automatic flush();
        per_hi.delete(); per_len.delete();
    endtask

    initial begin
        int w, n, pe0;
        // Async reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pe", period_end, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_period_sh", int'(dut.period_sh), 255);
        chk("rst_duty_sh", int'(dut.duty_sh), 0);
        @(negedge ck) rst = 1'b0;

        // Idle write duty=3 period=9, then run.
        do_write(3, 9, w);
        chk("idle_ack_delay", w, 1);
        en = 1'b1;
        flush();
        wait_pe(2);
        chk("p1_hi", per_hi[0], 3);
        chk("p1_len", per_len[0], 10);
        chk("p2_hi", per_hi[1], 3);
        chk("p2_len", per_len[1], 10);
        chk("ack_once", ack_total, 1);

        // Write duty=7 at cnt=2.
        wait_cnt(2);
        flush();
        do_write(7, 9, w);
        chk("run_ack_delay", w, 1);
        wait_pe(2);
        chk("cur_period_hi", per_hi[0], 3);
        chk("next_period_hi", per_hi[1], 7);

        // Back-to-back writes duty=5 then duty=1.
        wait_cnt(2);
        flush();
        do_write(5, 9, w);
        do_write(1, 9, w);
        #1;
        chk("stalled_ack_after_wrap", last_ack, last_pe + 1);
        wait_pe(2);
        chk("b2b_p0", per_hi[0], 7);
        chk("b2b_p1", per_hi[1], 5);
        chk("b2b_p2", per_hi[2], 1);

        // Duty extremes.
        do_write(0, 9, w);
        wait_pe(1); flush(); wait_pe(1);
        chk("duty0_hi", per_hi[0], 0);
        do_write(12, 9, w);
        wait_pe(1); flush(); wait_pe(1);
        chk("duty12_hi", per_hi[0], 10);
        chk("duty12_len", per_len[0], 10);

        // Drop en at cnt=4: finish the period, then idle.
        wait_cnt(4);
        pe0 = pe_total;
        en = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && (n == 0 || busy); i++) begin
            @(negedge ck);
            n++;
        end
        #1;
        chk("stop_cycles", n, 6);
        chk("stop_pe_count", pe_total - pe0, 1);
        chk("stop_pwm", pwm_out, 0);
        chk("stop_busy", busy, 0);

        // Reset between edges while running with pwm high.
        do_write(3, 9, w);
        en = 1'b1;
        @(posedge ck);
        #1 chk("pre_rst_pwm", pwm_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pe", period_end, 0);
        chk("mid_rst_ack", wr_ack, 0);
        chk("mid_rst_period_sh", int'(dut.period_sh), 255);
        chk("mid_rst_duty_sh", int'(dut.duty_sh), 0);
        en = 1'b0;
        @(negedge ck) rst = 1'b0;

        // Randomized traffic; the per-cycle compare does the checking.
        repeat (3000) begin
            @(negedge ck);
            if (wr_ack) wr_req = 1'b0;
            else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_duty   = 8'($urandom_range(0, 18));
                wr_period = 8'($urandom_range(0, 15));
                wr_req    = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the counter, duty and period width in bits.
REQ-002 The block SHALL have parameter PERIOD_RST, default 255, giving the active period value after reset.
REQ-003 The block SHALL have parameter DUTY_RST, default 0, giving the active duty value after reset.
REQ-004 The block SHALL have port ck, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; reset is asynchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit, the run request.
REQ-007 The block SHALL have port wr_req, input, 1 bit, the configuration write request, held high until acknowledged.
REQ-008 The block SHALL have port wr_duty, input, W bits, the requested duty in cycles, valid while wr_req is high.
REQ-009 The block SHALL have port wr_period, input, W bits, the requested period minus one, valid while wr_req is high.
REQ-010 The block SHALL have port wr_ack, output, 1 bit, a one-cycle acceptance pulse.
REQ-011 The block SHALL have port pwm_out, output, 1 bit, the registered PWM waveform.
REQ-012 The block SHALL have port period_end, output, 1 bit, a one-cycle pulse in the last cycle of each period.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL hold the active registers duty_sh and period_sh, one pending register set (pend_duty, pend_period, pend_v), and the counter cnt.
REQ-015 The state machine SHALL have three states: IDLE, RUN and STOP.
REQ-016 In IDLE, when en=1, the next state SHALL be RUN with cnt=0.
REQ-017 In RUN, when en=0, the next state SHALL be STOP.
REQ-018 In STOP, when en=1, the next state SHALL be RUN; the counter SHALL NOT restart.
REQ-019 In STOP, at wrap, the next state SHALL be IDLE.
REQ-020 In RUN and STOP, cnt SHALL increment every cycle.
REQ-021 When cnt==period_sh, cnt SHALL wrap to 0 on the next edge, and period_end SHALL be 1 in that cycle, so a period is period_sh+1 cycles.
REQ-022 In IDLE, cnt SHALL be 0, pwm_out SHALL be 0 and period_end SHALL be 0.
REQ-023 In RUN and STOP, pwm_out SHALL be 1 exactly in the cycles where cnt<duty_sh, with the register fed from the next-count comparison so there is no extra latency.
REQ-024 duty_sh=0 SHALL give a constant-low output, and duty_sh>period_sh SHALL give a constant-high output.
REQ-025 In IDLE, wr_req SHALL be accepted immediately, loading duty_sh and period_sh directly, with wr_ack=1 on the following cycle.
REQ-026 In RUN or STOP with pend_v=0, wr_req SHALL be captured into the pending registers, setting pend_v=1, with wr_ack=1 on the following cycle.
REQ-027 With pend_v=1, wr_ack SHALL stay 0 and the request SHALL stall.
REQ-028 At wrap with pend_v=1, the pending registers SHALL move to duty_sh and period_sh and pend_v SHALL clear; the new values SHALL govern the period beginning at cnt=0.
REQ-029 Simultaneous wrap and wr_req with pend_v=1 SHALL transfer the pending values to the active registers and accept the new request into pending in the same edge, with wr_ack on the next cycle.
REQ-030 Simultaneous wrap and wr_req with pend_v=0 SHALL capture the request into pending only; it SHALL apply at the following wrap.
REQ-031 wr_ack SHALL never be high for two consecutive cycles; wr_req SHALL be sampled again only after the cycle in which wr_ack is high.
REQ-032 Any pending write still held on entry to IDLE SHALL be applied to the active registers in the IDLE entry edge.

Reset
REQ-033 While rst=1, without waiting for a clock edge, the block SHALL set: state=IDLE, cnt=0, pwm_out=0, period_end=0, wr_ack=0, busy=0, pend_v=0, duty_sh=DUTY_RST, period_sh=PERIOD_RST.
REQ-034 Reset asserted mid-operation SHALL discard the pending write, and any unacknowledged wr_req SHALL be re-evaluated after release.
REQ-035 After rst is deasserted, the first state change SHALL occur on the next rising edge of ck.

Verification
REQ-036 The bench SHALL cover a write of period=9 and duty=3 in IDLE, then en=1: wr_ack is pulsed once, pwm_out runs 3 cycles high then 7 low, and period_end pulses every 10 cycles.
REQ-037 The bench SHALL cover a write of duty=7 at cnt=2: wr_ack follows one cycle later, the current period stays at 3 high, and the next period is 7 high.
REQ-038 The bench SHALL cover two back-to-back writes (duty=5, then duty=1): the second wr_ack is delayed until the cycle after the wrap, the first write applies at that wrap, and the second applies one period later.
REQ-039 The bench SHALL cover duty=0, giving pwm_out constant 0, and duty=12 with period=9, giving pwm_out constant 1 for a full period.
REQ-040 The bench SHALL cover en dropped at cnt=4: counting continues to cnt=9, period_end pulses, the block then reaches IDLE, pwm_out=0 and busy=0.
REQ-041 The bench SHALL cover rst pulsed between clock edges during RUN: all outputs go to 0 before the next edge, and period_sh reads back 255 and duty_sh reads back 0.
